// File: rtl/req_gnt_initiator.sv
// req_gnt_initiator: requester-side master for the req/gnt handshake with latency, count and timeout reporting
module req_gnt_initiator #(
  parameter int TIMEOUT = 8,
  parameter int LAT_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             gnt,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             spurious_gnt,
  output logic [LAT_W-1:0] last_latency,
  output logic [CNT_W-1:0] txn_count
);
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
  state_t state, state_n;
  logic [LAT_W-1:0] wcnt, wcnt_n, lat_n;
  logic [CNT_W-1:0] cnt_n;
  logic [LAT_W:0] winc;
  logic hit, done_n, to_n, sp_n;
  assign winc = {1'b0, wcnt} + (LAT_W+1)'(1);
  assign hit = winc == (LAT_W+1)'(TIMEOUT);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    wcnt_n = wcnt;
    lat_n = last_latency;
    cnt_n = txn_count;
    done_n = 1'b0;
    to_n = 1'b0;
    sp_n = 1'b0;
    case (state)
      IDLE: begin
        sp_n = gnt;
        if (start) begin
          state_n = REQ;
          wcnt_n = '0;
        end
      end
      REQ: begin
        if (gnt) begin
          state_n = RELEASE;
          wcnt_n = '0;
          cnt_n = txn_count + CNT_W'(1);
          lat_n = winc[LAT_W] ? '1 : winc[LAT_W-1:0];
        end else if (hit) begin
          state_n = RELEASE;
          wcnt_n = '0;
          to_n = 1'b1;
        end else wcnt_n = winc[LAT_W-1:0];
      end
      RELEASE: begin
        if (!gnt) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else if (hit) begin
          state_n = IDLE;
          done_n = 1'b1;
          to_n = 1'b1;
        end else wcnt_n = winc[LAT_W-1:0];
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      req <= 1'b0;
      done <= 1'b0;
      timeout_err <= 1'b0;
      spurious_gnt <= 1'b0;
      last_latency <= '0;
      txn_count <= '0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
      req <= state_n == REQ;
      done <= done_n;
      timeout_err <= to_n;
      spurious_gnt <= sp_n;
      last_latency <= lat_n;
      txn_count <= cnt_n;
    end
  end
endmodule
